morse_player: RTL and testbench

Downstream consumer of the UART receive buffer. It reads ASCII bytes from the 1024x8 character RAM in the order they were written, from its own read pointer up to the writer's pointer. It converts each byte to International Morse and keys a 1-bit output (LED/buzzer) using unit-based timing. It stops when the buffer is empty and resumes automatically when new bytes arrive.

---
 rtl/morse_pkg.sv | 22 ++
 rtl/morse_rom.sv | 57 +++++
 rtl/morse_player.sv | 136 +++++++++++++
 tb/tb_morse_player.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse player: FSM states, unit counts and code-word widths.
package morse_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_KEY_ON,
      S_KEY_OFF,
      S_GAP
   } state_t;

   localparam logic [2:0] DOT_U      = 3'd1;
   localparam logic [2:0] DASH_U     = 3'd3;
   localparam logic [2:0] ELEM_GAP_U = 3'd1;
   localparam logic [2:0] CHAR_GAP_U = 3'd3;
   localparam logic [2:0] WORD_GAP_U = 3'd7;

   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam int LEN_W = 3;
   localparam int PAT_W = 6;
endpackage

// File: rtl/morse_rom.sv
// Uppercase ASCII to Morse code word; pattern is right-aligned in len bits, first element
// in the highest used bit, 0 = dot, 1 = dash.
module morse_rom
   import morse_pkg::*;
(
   input  logic [7:0]       ch,
   output logic             valid,
   output logic [LEN_W-1:0] len,
   output logic [PAT_W-1:0] pat
);
   logic [LEN_W+PAT_W:0] code;

   always_comb begin
      code = '0;
      case (ch)
         8'h41: code = {1'b1, 3'd2, 6'b000001};  // A .-
         8'h42: code = {1'b1, 3'd4, 6'b001000};
         8'h43: code = {1'b1, 3'd4, 6'b001010};
         8'h44: code = {1'b1, 3'd3, 6'b000100};
         8'h45: code = {1'b1, 3'd1, 6'b000000};
         8'h46: code = {1'b1, 3'd4, 6'b000010};
         8'h47: code = {1'b1, 3'd3, 6'b000110};
         8'h48: code = {1'b1, 3'd4, 6'b000000};
         8'h49: code = {1'b1, 3'd2, 6'b000000};
         8'h4A: code = {1'b1, 3'd4, 6'b000111};
         8'h4B: code = {1'b1, 3'd3, 6'b000101};
         8'h4C: code = {1'b1, 3'd4, 6'b000100};
         8'h4D: code = {1'b1, 3'd2, 6'b000011};
         8'h4E: code = {1'b1, 3'd2, 6'b000010};
         8'h4F: code = {1'b1, 3'd3, 6'b000111};
         8'h50: code = {1'b1, 3'd4, 6'b000110};
         8'h51: code = {1'b1, 3'd4, 6'b001101};
         8'h52: code = {1'b1, 3'd3, 6'b000010};
         8'h53: code = {1'b1, 3'd3, 6'b000000};
         8'h54: code = {1'b1, 3'd1, 6'b000001};
         8'h55: code = {1'b1, 3'd3, 6'b000001};
         8'h56: code = {1'b1, 3'd4, 6'b000001};
         8'h57: code = {1'b1, 3'd3, 6'b000011};
         8'h58: code = {1'b1, 3'd4, 6'b001001};
         8'h59: code = {1'b1, 3'd4, 6'b001011};
         8'h5A: code = {1'b1, 3'd4, 6'b001100};
         8'h30: code = {1'b1, 3'd5, 6'b011111};
         8'h31: code = {1'b1, 3'd5, 6'b001111};
         8'h32: code = {1'b1, 3'd5, 6'b000111};
         8'h33: code = {1'b1, 3'd5, 6'b000011};
         8'h34: code = {1'b1, 3'd5, 6'b000001};
         8'h35: code = {1'b1, 3'd5, 6'b000000};
         8'h36: code = {1'b1, 3'd5, 6'b010000};
         8'h37: code = {1'b1, 3'd5, 6'b011000};
         8'h38: code = {1'b1, 3'd5, 6'b011100};
         8'h39: code = {1'b1, 3'd5, 6'b011110};
         default: code = '0;
      endcase
   end

   assign {valid, len, pat} = code;
endmodule

// File: rtl/morse_player.sv
// Drains the character buffer between address_r and address_w and keys each byte as Morse.
//
// state     | meaning
// IDLE      | buffer empty, waiting for address_w to move
// FETCH     | RAM is sampling address_r
// LOAD      | data_r valid: decode, advance pointer, start character or word gap
// KEY_ON    | element tone (1 unit dot, 3 units dash)
// KEY_OFF   | 1 unit gap between elements of one character
// GAP       | character gap (3 units) or word gap (7 units)
module morse_player
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 2700000,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address_w,
   input  logic [7:0]        data_r,
   output logic [ADDR_W-1:0] address_r,
   output logic              morse_out,
   output logic              busy
);
   localparam int CYC_W = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [CYC_W-1:0] CYC_RELOAD = CYC_W'(UNIT_CYCLES - 1);

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_n;
   logic              out_n;
   logic [CYC_W-1:0]  cyc_cnt, cyc_n;
   logic [2:0]        unit_cnt, unit_n;
   logic [LEN_W-1:0]  rem_cnt, rem_n;
   logic [PAT_W-1:0]  pat_sh, pat_n;

   logic [7:0]        ch_up;
   logic              rom_valid;
   logic [LEN_W-1:0]  rom_len;
   logic [PAT_W-1:0]  rom_pat;
   logic [PAT_W-1:0]  pat_al;
   logic              tick, expire, pending;

   assign ch_up = (data_r >= 8'h61 && data_r <= 8'h7A) ? data_r - 8'h20 : data_r;

   morse_rom u_rom (
      .ch    (ch_up),
      .valid (rom_valid),
      .len   (rom_len),
      .pat   (rom_pat)
   );

   // Left-align the code so the next element is always the MSB of pat_sh.
   assign pat_al  = rom_pat << (3'(PAT_W) - rom_len);
   assign tick    = (cyc_cnt == '0);
   assign expire  = tick && (unit_cnt == 3'd1);
   assign pending = (address_r != address_w);
   assign busy    = (state != S_IDLE);

   always_comb begin
      state_n = state;
      addr_n  = address_r;
      out_n   = morse_out;
      cyc_n   = cyc_cnt;
      unit_n  = unit_cnt;
      rem_n   = rem_cnt;
      pat_n   = pat_sh;

      if (state inside {S_KEY_ON, S_KEY_OFF, S_GAP}) begin
         if (tick) begin
            cyc_n  = CYC_RELOAD;
            unit_n = unit_cnt - 3'd1;
         end else begin
            cyc_n = cyc_cnt - 1'b1;
         end
      end

      case (state)
         S_IDLE: if (pending) state_n = S_FETCH;
         S_FETCH: state_n = S_LOAD;
         S_LOAD: begin
            addr_n = address_r + 1'b1;
            cyc_n  = CYC_RELOAD;
            if (rom_valid) begin
               state_n = S_KEY_ON;
               out_n   = 1'b1;
               unit_n  = pat_al[PAT_W-1] ? DASH_U : DOT_U;
               pat_n   = pat_al << 1;
               rem_n   = rom_len - 3'd1;
            end else if (ch_up == ASCII_SPACE) begin
               state_n = S_GAP;
               unit_n  = WORD_GAP_U;
            end else begin
               state_n = (addr_n != address_w) ? S_FETCH : S_IDLE;
            end
         end
         S_KEY_ON: if (expire) begin
            out_n = 1'b0;
            if (rem_cnt != '0) begin
               state_n = S_KEY_OFF;
               unit_n  = ELEM_GAP_U;
            end else begin
               state_n = S_GAP;
               unit_n  = CHAR_GAP_U;
            end
         end
         S_KEY_OFF: if (expire) begin
            state_n = S_KEY_ON;
            out_n   = 1'b1;
            unit_n  = pat_sh[PAT_W-1] ? DASH_U : DOT_U;
            pat_n   = pat_sh << 1;
            rem_n   = rem_cnt - 3'd1;
         end
         S_GAP: if (expire) state_n = pending ? S_FETCH : S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         address_r <= '0;
         morse_out <= 1'b0;
         cyc_cnt   <= '0;
         unit_cnt  <= '0;
         rem_cnt   <= '0;
         pat_sh    <= '0;
      end else begin
         state     <= state_n;
         address_r <= addr_n;
         morse_out <= out_n;
         cyc_cnt   <= cyc_n;
         unit_cnt  <= unit_n;
         rem_cnt   <= rem_n;
         pat_sh    <= pat_n;
      end
   end
endmodule

// File: tb/tb_morse_player.sv
// Self-checking bench for morse_player: fixed character table, randomized strings against a
// Morse timing model, pointer wrap and asynchronous reset mid-element.
module tb_morse_player;
   localparam int UNIT = 4;

   typedef struct {
      logic [7:0] ch;
      int         exp_high;
      int         exp_busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] address_w = '0;
   logic [9:0] address_r;
   logic [7:0] data_r;
   logic       morse_out;
   logic       busy;

   logic [7:0] mem [1024];
   int         checks = 0;
   int         errors = 0;
   bit         exp_q[$];
   bit         got_q[$];
   logic [9:0] ptr = '0;

   string code [36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
   };

   morse_player #(.UNIT_CYCLES(UNIT), .ADDR_W(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .address_w (address_w),
      .data_r    (data_r),
      .address_r (address_r),
      .morse_out (morse_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) data_r <= mem[address_r];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Expected key samples while busy: 2 cycles fetching, then the character body.
   task automatic model_byte(input logic [7:0] b);
      logic [7:0] u;
      int         idx;
      string      s;
      u = b;
      if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
      idx = -1;
      if (u >= 8'h41 && u <= 8'h5A) idx = int'(u) - 65;
      if (u >= 8'h30 && u <= 8'h39) idx = 26 + int'(u) - 48;
      repeat (2) exp_q.push_back(1'b0);
      if (u == 8'h20) begin
         repeat (7 * UNIT) exp_q.push_back(1'b0);
      end else if (idx >= 0) begin
         s = code[idx];
         for (int i = 0; i < s.len(); i++) begin
            if (i > 0) repeat (UNIT) exp_q.push_back(1'b0);
            repeat ((s[i] == 8'h2D) ? 3 * UNIT : UNIT) exp_q.push_back(1'b1);
         end
         repeat (3 * UNIT) exp_q.push_back(1'b0);
      end
   endtask

   // Release bytes up to w_first, optionally move the writer to w_final mid-character,
   // and record morse_out on every cycle busy is high.
   task automatic run_seq(input logic [9:0] w_first, input logic [9:0] w_final,
                          input int late, input string name);
      bit done;
      done = 1'b0;
      got_q.delete();
      @(negedge clk);
      address_w = w_first;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (c == late) address_w = w_final;
         if (!busy) begin
            done = 1'b1;
            break;
         end
         got_q.push_back(morse_out);
      end
      chk({name, " finished"}, int'(done), 1);
      chk({name, " address_r"}, int'(address_r), int'(w_final));
   endtask

   task automatic compare_model(input string name);
      int bad;
      bad = -1;
      chk({name, " length"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] != exp_q[i] && bad < 0) bad = i;
      chk({name, " first wrong sample"}, bad, -1);
   endtask

   function automatic logic [7:0] rand_byte(input int kind);
      case (kind)
         0: return 8'(8'h41 + $urandom_range(0, 25));
         1: return 8'(8'h61 + $urandom_range(0, 25));
         2: return 8'(8'h30 + $urandom_range(0, 9));
         3: return 8'h20;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      vec_t vecs[$];
      int   bad;
      int   highs;
      int   first_hi;
      int   n;
      int   m;
      bit   ok;

      vecs = '{
         '{8'h45, 4, 18}, '{8'h61, 16, 34}, '{8'h54, 12, 26}, '{8'h23, 0, 2},
         '{8'h20, 0, 30}, '{8'h30, 60, 90}, '{8'h53, 12, 34}, '{8'h7A, 32, 58}
      };
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

      repeat (3) @(negedge clk);
      chk("reset address_r", int'(address_r), 0);
      chk("reset morse_out", int'(morse_out), 0);
      chk("reset busy", int'(busy), 0);
      rst = 1'b0;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (address_r != 0 || morse_out || busy) bad++;
      end
      chk("idle with empty buffer", bad, 0);

      // Single characters against hand-computed high time and busy length.
      foreach (vecs[k]) begin
         mem[ptr] = vecs[k].ch;
         run_seq(ptr + 10'd1, ptr + 10'd1, -1, $sformatf("char %02h", vecs[k].ch));
         highs = 0;
         first_hi = -1;
         foreach (got_q[i]) begin
            highs += int'(got_q[i]);
            if (got_q[i] && first_hi < 0) first_hi = i;
         end
         chk($sformatf("char %02h high cycles", vecs[k].ch), highs, vecs[k].exp_high);
         chk($sformatf("char %02h busy cycles", vecs[k].ch), got_q.size(), vecs[k].exp_busy);
         if (vecs[k].exp_high > 0)
            chk($sformatf("char %02h first rise", vecs[k].ch), first_hi, 2);
         ptr = ptr + 10'd1;
      end

      // "T T": busy must stay high across the word gap.
      mem[ptr] = 8'h54; mem[ptr + 10'd1] = 8'h20; mem[ptr + 10'd2] = 8'h54;
      exp_q.delete();
      model_byte(8'h54); model_byte(8'h20); model_byte(8'h54);
      run_seq(ptr + 10'd3, ptr + 10'd3, -1, "T T");
      compare_model("T T");
      ptr = ptr + 10'd3;

      // Random strings; some bytes arrive while the first character is still keying.
      for (int b = 0; b < 12; b++) begin
         n = $urandom_range(1, 4);
         m = $urandom_range(0, 3);
         exp_q.delete();
         for (int i = 0; i < n + m; i++) begin
            mem[ptr + 10'(i)] = (i == 0) ? rand_byte(0) : rand_byte($urandom_range(0, 4));
            model_byte(mem[ptr + 10'(i)]);
         end
         run_seq(ptr + 10'(n), ptr + 10'(n + m), (m > 0) ? 3 : -1, $sformatf("random %0d", b));
         compare_model($sformatf("random %0d", b));
         ptr = ptr + 10'(n + m);
      end

      // Skip bytes up to 0x3FF, then a dash stored at the last address.
      exp_q.delete();
      for (int a = int'(ptr); a < 1023; a++) begin
         mem[a] = 8'h23;
         model_byte(8'h23);
      end
      run_seq(10'h3FF, 10'h3FF, -1, "fill to 3FF");
      compare_model("fill to 3FF");
      mem[10'h3FF] = 8'h54;
      exp_q.delete();
      model_byte(8'h54);
      run_seq(10'h000, 10'h000, -1, "wrap T");
      compare_model("wrap T");

      // Asynchronous reset 5 cycles into a dash, between clock edges.
      mem[0] = 8'h54;
      @(negedge clk);
      address_w = 10'd1;
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (morse_out) begin
            ok = 1'b1;
            break;
         end
      end
      chk("dash started before reset", int'(ok), 1);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async reset morse_out", int'(morse_out), 0);
      chk("async reset address_r", int'(address_r), 0);
      chk("async reset busy", int'(busy), 0);
      address_w = 10'd0;
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy || morse_out || address_r != 0) bad++;
      end
      chk("idle after reset", bad, 0);
      exp_q.delete();
      model_byte(8'h54);
      run_seq(10'd1, 10'd1, -1, "T after reset");
      compare_model("T after reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
